// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the instruction ROM and buffers {pc, instr}
// pairs in a small in-order queue for decode. A redirect flushes the queue and restarts fetch.
module instr_fetch_unit #(
  parameter int          ROM_SIZE = 64,
  parameter int          ADDR_W   = $clog2(ROM_SIZE),
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [31:0]       fetch_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic             push, pop;

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign push      = !redirect_valid & ((count_q < DEPTH_C) | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      // A same-cycle handshake is treated as consumed and flushed with the rest.
      fetch_pc_d = redirect_pc & ~32'h3;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rd;
    end
  end

  assign imem_addr = fetch_pc_q[ADDR_W+1:2];
  assign fetch_pc  = fetch_pc_q;
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = instr_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model of the fetch stage.
module tb_instr_fetch_unit;

  localparam int ROM_SIZE = 64;
  localparam int DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rd, out_instr, out_pc, fetch_pc;
  logic        out_valid;

  logic        rst2, redirect_valid2, out_ready2;
  logic [31:0] redirect_pc2;
  logic [5:0]  imem_addr2;
  logic [31:0] imem_rd2, out_instr2, out_pc2, fetch_pc2;
  logic        out_valid2;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_fpc;
  logic [31:0] m_q[$];

  always #5 clk = ~clk;

  assign imem_rd  = 32'h1000_0000 + {26'b0, imem_addr};
  assign imem_rd2 = 32'h1000_0000 + {26'b0, imem_addr2};

  instr_fetch_unit #(.ROM_SIZE(ROM_SIZE), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fetch_pc(fetch_pc)
  );

  instr_fetch_unit #(.ROM_SIZE(ROM_SIZE), .RESET_PC(32'hF8), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .imem_addr(imem_addr2), .imem_rd(imem_rd2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_instr(out_instr2), .out_pc(out_pc2), .fetch_pc(fetch_pc2)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc / 4) % ROM_SIZE);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit do_pop, do_push;
    if (r) begin
      m_fpc = 32'h0;
      m_q.delete();
    end else if (rv) begin
      m_q.delete();
      m_fpc = {rpc[31:2], 2'b00};
    end else begin
      do_pop  = (m_q.size() > 0) && rdy;
      do_push = (m_q.size() < DEPTH) || do_pop;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    chk("fetch_pc", fetch_pc, m_fpc);
    chk("imem_addr", {26'b0, imem_addr}, (m_fpc / 4) % ROM_SIZE);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      chk("out_pc", out_pc, m_q[0]);
      chk("out_instr", out_instr, rom_word(m_q[0]));
    end
  endtask

  // One clock: drive inputs, update model at the edge, check at the falling edge.
  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    @(posedge clk);
    model_update(r, rv, rpc, rdy);
    @(negedge clk);
    compare_all();
  endtask

  logic [31:0] e2_pc    [4];
  logic [31:0] e2_instr [4];

  initial begin
    e2_pc    = '{32'hF8, 32'hFC, 32'h100, 32'h104};
    e2_instr = '{32'h1000_003E, 32'h1000_003F, 32'h1000_0000, 32'h1000_0001};
    rst2 = 1'b1; redirect_valid2 = 1'b0; redirect_pc2 = 32'h0; out_ready2 = 1'b1;
    m_fpc = 32'h0;

    // Reset state
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_pc", fetch_pc, 32'h0);
    chk("reset_valid2", {31'b0, out_valid2}, 32'd0);
    chk("reset_pc2", fetch_pc2, 32'hF8);
    rst2 = 1'b0;

    // Free run; second instance checks ROM address wrap from RESET_PC=0xF8
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 1);
      chk("stream_pc", out_pc, 32'(k * 4));
      if (k < 4) begin
        chk("wrap_valid2", {31'b0, out_valid2}, 32'd1);
        chk("wrap_pc2", out_pc2, e2_pc[k]);
        chk("wrap_instr2", out_instr2, e2_instr[k]);
      end
    end

    // Stall for 6 cycles, then release
    step(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
    chk("stall_fpc", fetch_pc, 32'h8);
    chk("stall_head_pc", out_pc, 32'h0);
    chk("stall_head_instr", out_instr, 32'h1000_0000);
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 1);
      chk("resume_pc", out_pc, 32'(k * 4));
    end

    // Redirect while the queue holds 8,12: aligned then misaligned target
    for (int v = 0; v < 2; v++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("pre_redir_head", out_pc, 32'h8);
      step(0, 1, (v == 0) ? 32'h40 : 32'h43, 1);
      chk("redir_valid", {31'b0, out_valid}, 32'd0);
      chk("redir_fpc", fetch_pc, 32'h40);
      step(0, 0, 0, 1);
      chk("redir_head_pc", out_pc, 32'h40);
      chk("redir_head_instr", out_instr, 32'h1000_0010);
      step(0, 0, 0, 1);
      chk("redir_next_pc", out_pc, 32'h44);
    end

    // Back-to-back redirects: last wins
    step(0, 1, 32'h80, 1);
    step(0, 1, 32'h20, 1);
    chk("b2b_fpc", fetch_pc, 32'h20);
    step(0, 0, 0, 1);
    chk("b2b_head", out_pc, 32'h20);

    // Reset with full queue and simultaneous redirect
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 32'h80, 0);
    chk("rst_redir_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_redir_fpc", fetch_pc, 32'h0);

    // 32-bit PC wrap
    step(0, 1, 32'hFFFF_FFF8, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), $urandom,
           ($urandom_range(0, 9) < 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage placed directly before the instruction ROM in the single-cycle/teaching CPU flow.
- Owns the program counter and drives the ROM word address. Captures the combinational ROM data into a small in-order fetch queue.
- Presents {pc, instruction} pairs to the decode stage over a valid/ready handshake.
- Accepts redirects from jump/branch resolution. A redirect flushes the queue and restarts fetch at the new PC.

Parameters:
- ROM_SIZE, 64, number of 32-bit words in the instruction ROM.
- ADDR_W, $clog2(ROM_SIZE), ROM word-address width.
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.
- DEPTH, 2, fetch queue entries; legal range 2..8.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  load redirect_pc and flush the queue.
- redirect_pc  in  32  new byte PC.
- imem_addr  out  ADDR_W  ROM word address, equal to fetch_pc[ADDR_W+1:2].
- imem_rd  in  32  ROM read data; combinational from imem_addr, same cycle.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  instruction at the queue head.
- out_pc  out  32  byte PC of out_instr.
- fetch_pc  out  32  current fetch PC (debug/trace).

Behaviour:
- Reset (rst=1 at a clock edge):
  - fetch_pc <= RESET_PC, queue count <= 0, read/write pointers <= 0.
  - Outputs after reset: out_valid=0, fetch_pc=RESET_PC, imem_addr=RESET_PC[ADDR_W+1:2]. out_instr/out_pc are don't-care while out_valid=0 and must not be checked.
  - Reset asserted mid-stream discards all queued entries and any redirect in the same cycle.
- Pop: pop = out_valid & out_ready.
- Push: push = !redirect_valid & (count < DEPTH | pop).
  - Push writes {fetch_pc, imem_rd} at the tail and advances fetch_pc <= fetch_pc + 4.
  - Push and pop in the same cycle on a full queue is legal. Count stays at DEPTH and throughput stays at 1 instruction/cycle.
- Latency: fetch_pc presented in cycle N appears at the head in cycle N+1 at the earliest. The first out_valid=1 is the first cycle after rst deasserts.
- Stall: while out_ready=0 the queue fills to DEPTH and stops.
  - With count=DEPTH and no pop: fetch_pc holds, imem_addr holds, no push.
  - out_instr/out_pc stay stable while out_valid=1 & out_ready=0.
- Redirect (redirect_valid=1, rst=0) has priority over push and pop:
  - count <= 0, pointers <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are silently cleared.
  - A handshake in the same cycle counts as completed by the consumer; the entry is discarded with the flush.
  - out_valid=0 in the cycle after the redirect. The first redirected instruction appears one cycle later.
  - Back-to-back redirects: the last one wins, and each one flushes.
- Arithmetic: fetch_pc is a full 32-bit register and wraps from 32'hFFFF_FFFC to 0. imem_addr truncates, so the ROM address wraps modulo ROM_SIZE words.
- Queue order is strictly FIFO. Pointers wrap modulo DEPTH. Count range is 0..DEPTH.

Test Plan:
- ROM word i = 32'h1000_0000+i; reset, out_ready=1 continuously -> out_valid from the first post-reset cycle; sequence (out_pc, out_instr) = (0,10000000),(4,10000001),(8,10000002)…, one per cycle, no gaps.
- out_ready=0 for 6 cycles after reset -> count saturates at 2, fetch_pc=8, head stays (0,10000000); on release the stream resumes 0,4,8,12 with no loss or duplication.
- redirect_valid=1, redirect_pc=32'h40 while the queue holds pc 8,12 -> next cycle out_valid=0, fetch_pc=0x40; following cycle head=(0x40,10000010); pc 8/12 never emitted.
- Redirect to 32'h43 -> fetch_pc=0x40 and behaviour is identical to the previous scenario.
- Free-run with RESET_PC=32'hF8 -> pc 0xF8, 0xFC, 0x100 fetch ROM words 62, 63, 0 (instr 1000003E, 1000003F, 10000000).
- rst pulsed for 1 cycle with a full queue and redirect_valid=1 -> queue empty, fetch_pc=RESET_PC, redirect ignored.
